gpr_wb_arbiter: RTL and testbench
=================================

Name: gpr_wb_arbiter

Overview:
- Shares the single write port of the 32x32 GPR file (we3/a3/wd3) among N_REQ writeback requesters, e.g. ALU, load unit and debug port.
- Round-robin arbitration with a valid/ready handshake per requester.
- One-entry registered output stage that stalls on wp_hold.
- Publishes a pending-write bitmap for hazard/stall logic.
- Sits between the execute/memory writeback sources and the GPR set.

Parameters:
- N_REQ, 3, number of writeback requesters (2..8).
- AW, 5, register address width (32 registers).
- DW, 32, data width.

Ports:
- clk  in  1  system clock; all state updates on posedge.
- reset  in  1  synchronous, active-high reset.
- req_valid  in  N_REQ  requester i has a write pending.
- req_addr  in  N_REQ*AW  flattened destination addresses; requester i at bits [i*AW +: AW].
- req_data  in  N_REQ*DW  flattened write data; requester i at bits [i*DW +: DW].
- req_ready  out  N_REQ  one-hot grant; the transfer occurs when req_valid[i] & req_ready[i].
- wp_hold  in  1  GPR write port frozen this cycle (e.g. debug halt).
- we3  out  1  GPR write enable.
- a3  out  AW  GPR write address.
- wd3  out  DW  GPR write data.
- reg_pending  out  32  bit r is set while the output stage holds a write to r.
- busy  out  1  output stage occupied.

Behaviour:
- Reset values (synchronous, reset has priority over everything):
  - out_valid=0, a3=0, wd3=0, rr_ptr=N_REQ-1.
  - Hence we3=0, req_ready=0, reg_pending=0, busy=0.
- Output stage: registers out_valid, a3, wd3.
  - we3 = out_valid & ~wp_hold (combinational from registers).
  - busy = out_valid.
  - reg_pending = out_valid ? (1<<a3) : 0.
- Drain: stage frees at the clock edge when out_valid & ~wp_hold.
  - can_load = ~out_valid | ~wp_hold.
- Arbitration (combinational):
  - When can_load, grant the first i with req_valid[i], scanning from (rr_ptr+1) mod N_REQ upward with wrap.
  - req_ready = one-hot of the granted index; all zero if none valid or ~can_load.
  - Exactly one grant per cycle maximum.
  - req_ready never depends on the requester's own req_ready; it may depend on req_valid.
- On a transfer (granted index g):
  - rr_ptr <= g.
  - If req_addr[g] != 0: out_valid<=1, a3<=req_addr[g], wd3<=req_data[g].
  - If req_addr[g] == 0: the write is accepted and discarded; out_valid <= 0 if the stage drained this cycle, else unchanged.
- No transfer: out_valid <= out_valid & wp_hold; a3/wd3 hold their values.
- Latency: request accepted at edge k gives we3 high during cycle k+1, GPR updated at edge k+2 (if no hold).
- Throughput: one write per cycle when wp_hold=0.
- Boundary conditions:
  - wp_hold=1 with out_valid=1: req_ready=0, stage frozen, we3=0, reg_pending keeps its bit.
  - wp_hold=1 with out_valid=0: one request may still be accepted into the empty stage.
  - Requester drops valid without a grant: allowed, no state change.
  - The same address from two requesters: serialized in grant order; the last write wins.
  - Reset mid-hold: the stage is flushed and the write is lost; the requester must re-request.

Decomposition:
- Shared package/header gpr_pkg holds constants: GPR_AW=5, GPR_DW=32, GPR_COUNT=32, GPR_ZERO=0.
- One sub-module is natural: rr_arbiter.
  - Parameter N.
  - Inputs: req, ptr, en.
  - Output: one-hot gnt.
  - Pure combinational; reusable for bus arbitration.
- The parent module owns rr_ptr and the output stage.

Test Plan:
1. Reset, then req_valid=3'b001, addr=5, data=32'hDEAD_BEEF → req_ready=001 at cycle 0; we3=1, a3=5, wd3=DEADBEEF, reg_pending=32'h20 at cycle 1; we3=0 at cycle 2.
2. All three valid continuously, addrs 1/2/3 → grants cycle through 001,010,100,001; we3 high every cycle with a3 sequence 1,2,3,1.
3. Stage loaded (a3=7), wp_hold=1 for 3 cycles with req_valid=010 → req_ready=0, we3=0, reg_pending bit 7 held; hold released → we3=1 for a3=7, then the next cycle we3=1 for requester 1.
4. req_valid=001, addr=0 → req_ready=001, we3 stays 0, reg_pending=0; rr_ptr advances, so the next simultaneous 011 request grants 010.
5. Stage loaded, reset=1 asserted for one cycle with wp_hold=1 → next cycle out_valid=0, we3=0, reg_pending=0, req_ready=0; after release, a new request is granted starting from index 0.
6. Requesters 0 and 2 both write addr 9 (data 1, then 2) on consecutive grants → we3 pulses twice with wd3 1 then 2; the GPR holds 2.

Source files
------------

// File: rtl/gpr_pkg.sv
// ----------------------------------------------------------------------------
// gpr_pkg
// Shared constants for the 32x32 general-purpose register file and the
// logic that writes into it.
//   GPR_AW    : register address width
//   GPR_DW    : register data width
//   GPR_COUNT : number of architectural registers
//   GPR_ZERO  : address of the hard-wired zero register (writes are dropped)
// ----------------------------------------------------------------------------
package gpr_pkg;

  localparam int GPR_AW    = 5;
  localparam int GPR_DW    = 32;
  localparam int GPR_COUNT = 32;

  localparam logic [GPR_AW-1:0] GPR_ZERO = '0;

  // One-hot mask of a register address, used for pending-write bitmaps.
  function automatic logic [GPR_COUNT-1:0] gpr_mask(input logic [GPR_AW-1:0] addr);
    return GPR_COUNT'(1) << addr;
  endfunction

endpackage

// File: rtl/gpr_wb_arbiter_rr_arbiter.sv
// ----------------------------------------------------------------------------
// rr_arbiter
// Purely combinational round-robin arbiter. The search for a requester starts
// just after the last winner (ptr) and wraps, so every requester is reached
// within N grants.
//   req : request vector, bit i = requester i wants service
//   ptr : index of the previous winner; priority starts at ptr+1 (mod N)
//   en  : grant enable; when low no grant is issued
//   gnt : one-hot grant, all zero when en is low or nothing is requested
// ----------------------------------------------------------------------------
module rr_arbiter #(
  parameter  int N  = 3,
  localparam int PW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] ptr,
  input  logic          en,
  output logic [N-1:0]  gnt
);

  // One extra bit so ptr + N cannot overflow before the wrap correction.
  logic [PW:0]   sum;
  logic [PW-1:0] idx;
  logic          found;

  // NOTE: every variable written in a combinational block gets a default
  // first; otherwise a path that skips the assignment infers a latch.
  always_comb begin
    gnt   = '0;
    found = 1'b0;
    sum   = '0;
    idx   = '0;
    for (int k = 1; k <= N; k++) begin
      sum = {1'b0, ptr} + (PW+1)'(k);
      if (sum >= (PW+1)'(N)) begin
        sum = sum - (PW+1)'(N);
      end
      idx = sum[PW-1:0];
      if (en && !found && req[idx]) begin
        gnt[idx] = 1'b1;
        found    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/gpr_wb_arbiter.sv
// ----------------------------------------------------------------------------
// gpr_wb_arbiter
// Shares the single write port (we3/a3/wd3) of the GPR file between N_REQ
// writeback sources (ALU, load unit, debug, ...). Requests are served
// round-robin through a valid/ready handshake and land in a one-entry
// registered output stage that drives the GPR write port.
//
// Ports
//   clk         : system clock, all state changes on the rising edge
//   reset       : synchronous, active-high; flushes the output stage
//   req_valid   : requester i has a write pending
//   req_addr    : flattened destination addresses, requester i at [i*AW +: AW]
//   req_data    : flattened write data, requester i at [i*DW +: DW]
//   req_ready   : one-hot grant; a transfer is req_valid[i] & req_ready[i]
//   wp_hold     : GPR write port frozen this cycle
//   we3/a3/wd3  : GPR write enable / address / data
//   reg_pending : bit r set while the output stage holds a write to r
//   busy        : output stage occupied
//
// Writes to register 0 are accepted (so the requester retires them) but never
// reach the output stage, since that register is hard-wired to zero.
// ----------------------------------------------------------------------------
module gpr_wb_arbiter
  import gpr_pkg::*;
#(
  parameter int N_REQ = 3,
  parameter int AW    = GPR_AW,
  parameter int DW    = GPR_DW
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [N_REQ-1:0]     req_valid,
  input  logic [N_REQ*AW-1:0]  req_addr,
  input  logic [N_REQ*DW-1:0]  req_data,
  output logic [N_REQ-1:0]     req_ready,
  input  logic                 wp_hold,
  output logic                 we3,
  output logic [AW-1:0]        a3,
  output logic [DW-1:0]        wd3,
  output logic [GPR_COUNT-1:0] reg_pending,
  output logic                 busy
);

  localparam int PW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  localparam logic [PW-1:0] PTR_RESET = PW'(N_REQ - 1);

  logic          out_valid;
  logic [PW-1:0] rr_ptr;
  logic          can_load;
  logic [N_REQ-1:0] gnt;
  logic          transfer;
  logic [PW-1:0] gnt_idx;
  logic [AW-1:0] sel_addr;
  logic [DW-1:0] sel_data;

  // The stage can take a new entry when it is empty or is draining this edge.
  assign can_load = ~out_valid | ~wp_hold;

  rr_arbiter #(
    .N (N_REQ)
  ) u_rr_arbiter (
    .req (req_valid),
    .ptr (rr_ptr),
    .en  (can_load),
    .gnt (gnt)
  );

  // The arbiter only grants valid requesters, so any grant is a transfer.
  assign req_ready = gnt;
  assign transfer  = |gnt;

  // Encode the one-hot grant and steer the winner's address/data.
  always_comb begin
    gnt_idx  = '0;
    sel_addr = '0;
    sel_data = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (gnt[i]) begin
        gnt_idx  = PW'(i);
        sel_addr = req_addr[i*AW +: AW];
        sel_data = req_data[i*DW +: DW];
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid <= 1'b0;
      a3        <= '0;
      wd3       <= '0;
      rr_ptr    <= PTR_RESET;
    end else begin
      if (transfer) begin
        rr_ptr <= gnt_idx;
      end
      if (transfer && (sel_addr != AW'(GPR_ZERO))) begin
        out_valid <= 1'b1;
        a3        <= sel_addr;
        wd3       <= sel_data;
      end else begin
        // Either nothing was accepted or a write to r0 was dropped: the
        // stage empties if it drained, otherwise it keeps its entry.
        out_valid <= out_valid & wp_hold;
      end
    end
  end

  assign we3         = out_valid & ~wp_hold;
  assign busy        = out_valid;
  assign reg_pending = out_valid ? (GPR_COUNT'(1) << a3) : '0;

  // Handshake sanity: at most one grant, and only to a valid requester.
  a_gnt_onehot : assert property (@(posedge clk) disable iff (reset)
    $onehot0(req_ready));
  a_gnt_valid : assert property (@(posedge clk) disable iff (reset)
    ((req_ready & ~req_valid) == '0));
  a_no_grant_when_frozen : assert property (@(posedge clk) disable iff (reset)
    (out_valid && wp_hold) |-> (req_ready == '0));

endmodule

// File: tb/tb_gpr_wb_arbiter.sv
// ----------------------------------------------------------------------------
// tb_gpr_wb_arbiter
// Directed scenarios followed by a randomized run against a reference model.
// The model keeps the output stage as a queue of pending writes, the fairness
// state as the index of the last winner, and the GPR file as an array.
// ----------------------------------------------------------------------------
module tb_gpr_wb_arbiter;

  localparam int N  = 3;
  localparam int AW = 5;
  localparam int DW = 32;

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } wr_t;

  logic            clk = 1'b0;
  logic            reset;
  logic [N-1:0]    req_valid;
  logic [N*AW-1:0] req_addr;
  logic [N*DW-1:0] req_data;
  logic [N-1:0]    req_ready;
  logic            wp_hold;
  logic            we3;
  logic [AW-1:0]   a3;
  logic [DW-1:0]   wd3;
  logic [31:0]     reg_pending;
  logic            busy;

  always #5 clk = ~clk;

  gpr_wb_arbiter #(
    .N_REQ (N),
    .AW    (AW),
    .DW    (DW)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .req_valid   (req_valid),
    .req_addr    (req_addr),
    .req_data    (req_data),
    .req_ready   (req_ready),
    .wp_hold     (wp_hold),
    .we3         (we3),
    .a3          (a3),
    .wd3         (wd3),
    .reg_pending (reg_pending),
    .busy        (busy)
  );

  int n_vec = 0;
  int n_err = 0;

  // Reference model state
  wr_t           stage_q[$];
  int            last_g;
  logic [AW-1:0] last_addr;
  logic [DW-1:0] last_data;
  logic [DW-1:0] model_gpr[32];
  logic [DW-1:0] dut_gpr[32];

  // Model expectations for the current cycle
  int            exp_g;
  logic [N-1:0]  exp_ready;
  logic          exp_we3;
  logic [31:0]   exp_pending;
  logic          exp_busy;

  task automatic model_eval();
    bit can_load;
    can_load = (stage_q.size() == 0) || !wp_hold;
    exp_g = -1;
    if (can_load) begin
      for (int k = 1; k <= N; k++) begin
        int i;
        i = (last_g + k) % N;
        if (exp_g < 0 && req_valid[i]) exp_g = i;
      end
    end
    exp_ready   = (exp_g >= 0) ? (N'(1) << exp_g) : '0;
    exp_we3     = (stage_q.size() != 0) && !wp_hold;
    exp_busy    = (stage_q.size() != 0);
    exp_pending = (stage_q.size() != 0) ? (32'(1) << stage_q[0].addr) : 32'h0;
  endtask

  task automatic model_commit();
    logic [AW-1:0] a;
    logic [DW-1:0] d;
    if (exp_we3) begin
      model_gpr[stage_q[0].addr] = stage_q[0].data;
      void'(stage_q.pop_front());
    end
    if (reset) begin
      stage_q.delete();
      last_g    = N - 1;
      last_addr = '0;
      last_data = '0;
    end else if (exp_g >= 0) begin
      last_g = exp_g;
      a = req_addr[exp_g*AW +: AW];
      d = req_data[exp_g*DW +: DW];
      if (a != 0) begin
        stage_q.push_back('{addr: a, data: d});
        last_addr = a;
        last_data = d;
      end
    end
  endtask

  // Let inputs settle and compute what the outputs should be this cycle.
  task automatic settle();
    #1;
    model_eval();
  endtask

  // Advance one clock: record the GPR write the DUT presents, update the
  // model, and return at the following falling edge.
  task automatic tick();
    if (we3 === 1'b1) dut_gpr[a3] = wd3;
    model_commit();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic set_req(input int i, input logic [AW-1:0] a, input logic [DW-1:0] d);
    req_addr[i*AW +: AW] = a;
    req_data[i*DW +: DW] = d;
  endtask

  task automatic do_reset();
    reset     = 1'b1;
    req_valid = '0;
    wp_hold   = 1'b0;
    req_addr  = '0;
    req_data  = '0;
    settle();
    tick();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    settle();
    n_vec++; if (we3 !== 1'b0) begin n_err++; $display("FAIL reset_we3: got %b want 0", we3); end
    n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %b want 0", busy); end
    n_vec++; if (reg_pending !== 32'h0) begin n_err++; $display("FAIL reset_pending: got %h want 0", reg_pending); end
    n_vec++; if (req_ready !== 3'b000) begin n_err++; $display("FAIL reset_ready: got %b want 000", req_ready); end
    n_vec++; if (a3 !== 5'd0 || wd3 !== 32'h0) begin n_err++; $display("FAIL reset_a3_wd3: got %h/%h want 0/0", a3, wd3); end
    tick();
  endtask

  task automatic test_single_write();
    do_reset();
    set_req(0, 5'd5, 32'hDEAD_BEEF);
    req_valid = 3'b001;
    settle();
    n_vec++; if (req_ready !== 3'b001) begin n_err++; $display("FAIL single_ready: got %b want 001", req_ready); end
    tick();
    req_valid = 3'b000;
    settle();
    n_vec++; if (we3 !== 1'b1) begin n_err++; $display("FAIL single_we3: got %b want 1", we3); end
    n_vec++; if (a3 !== 5'd5) begin n_err++; $display("FAIL single_a3: got %0d want 5", a3); end
    n_vec++; if (wd3 !== 32'hDEAD_BEEF) begin n_err++; $display("FAIL single_wd3: got %h want deadbeef", wd3); end
    n_vec++; if (reg_pending !== 32'h20) begin n_err++; $display("FAIL single_pending: got %h want 00000020", reg_pending); end
    tick();
    settle();
    n_vec++; if (we3 !== 1'b0) begin n_err++; $display("FAIL single_we3_off: got %b want 0", we3); end
    tick();
  endtask

  task automatic test_round_robin();
    logic [2:0] g_exp[4] = '{3'b001, 3'b010, 3'b100, 3'b001};
    logic [4:0] a_exp[3] = '{5'd1, 5'd2, 5'd3};
    do_reset();
    set_req(0, 5'd1, 32'h100);
    set_req(1, 5'd2, 32'h200);
    set_req(2, 5'd3, 32'h300);
    req_valid = 3'b111;
    for (int c = 0; c < 5; c++) begin
      settle();
      if (c < 4) begin
        n_vec++; if (req_ready !== g_exp[c]) begin n_err++; $display("FAIL rr_ready[%0d]: got %b want %b", c, req_ready, g_exp[c]); end
      end
      if (c >= 1) begin
        n_vec++; if (we3 !== 1'b1 || a3 !== a_exp[(c-1)%3]) begin n_err++; $display("FAIL rr_write[%0d]: got we3=%b a3=%0d want we3=1 a3=%0d", c, we3, a3, a_exp[(c-1)%3]); end
      end
      tick();
    end
    req_valid = 3'b000;
    settle();
    tick();
  endtask

  task automatic test_hold();
    do_reset();
    set_req(0, 5'd7, 32'h0000_0077);
    req_valid = 3'b001;
    settle();
    tick();
    set_req(1, 5'd12, 32'h0000_1200);
    req_valid = 3'b010;
    wp_hold   = 1'b1;
    for (int c = 0; c < 3; c++) begin
      settle();
      n_vec++; if (req_ready !== 3'b000) begin n_err++; $display("FAIL hold_ready[%0d]: got %b want 000", c, req_ready); end
      n_vec++; if (we3 !== 1'b0) begin n_err++; $display("FAIL hold_we3[%0d]: got %b want 0", c, we3); end
      n_vec++; if (reg_pending !== 32'h80) begin n_err++; $display("FAIL hold_pending[%0d]: got %h want 00000080", c, reg_pending); end
      tick();
    end
    wp_hold = 1'b0;
    settle();
    n_vec++; if (we3 !== 1'b1 || a3 !== 5'd7) begin n_err++; $display("FAIL hold_release: got we3=%b a3=%0d want we3=1 a3=7", we3, a3); end
    n_vec++; if (req_ready !== 3'b010) begin n_err++; $display("FAIL hold_release_ready: got %b want 010", req_ready); end
    tick();
    req_valid = 3'b000;
    settle();
    n_vec++; if (we3 !== 1'b1 || a3 !== 5'd12 || wd3 !== 32'h1200) begin n_err++; $display("FAIL hold_next: got we3=%b a3=%0d wd3=%h want 1/12/00001200", we3, a3, wd3); end
    tick();
  endtask

  task automatic test_zero_addr();
    do_reset();
    set_req(0, 5'd0, 32'h0000_0ABC);
    req_valid = 3'b001;
    settle();
    n_vec++; if (req_ready !== 3'b001) begin n_err++; $display("FAIL zero_ready: got %b want 001", req_ready); end
    tick();
    set_req(1, 5'd4, 32'h0000_0044);
    req_valid = 3'b011;
    settle();
    n_vec++; if (we3 !== 1'b0 || busy !== 1'b0) begin n_err++; $display("FAIL zero_dropped: got we3=%b busy=%b want 0/0", we3, busy); end
    n_vec++; if (reg_pending !== 32'h0) begin n_err++; $display("FAIL zero_pending: got %h want 0", reg_pending); end
    n_vec++; if (req_ready !== 3'b010) begin n_err++; $display("FAIL zero_ptr_adv: got %b want 010", req_ready); end
    tick();
    req_valid = 3'b000;
    settle();
    n_vec++; if (we3 !== 1'b1 || a3 !== 5'd4) begin n_err++; $display("FAIL zero_next: got we3=%b a3=%0d want 1/4", we3, a3); end
    tick();
  endtask

  task automatic test_reset_mid_hold();
    do_reset();
    set_req(0, 5'd3, 32'h0000_0033);
    req_valid = 3'b001;
    settle();
    tick();
    req_valid = 3'b000;
    wp_hold   = 1'b1;
    reset     = 1'b1;
    settle();
    tick();
    reset = 1'b0;
    settle();
    n_vec++; if (busy !== 1'b0 || we3 !== 1'b0) begin n_err++; $display("FAIL rsthold_flush: got busy=%b we3=%b want 0/0", busy, we3); end
    n_vec++; if (reg_pending !== 32'h0) begin n_err++; $display("FAIL rsthold_pending: got %h want 0", reg_pending); end
    n_vec++; if (req_ready !== 3'b000) begin n_err++; $display("FAIL rsthold_ready: got %b want 000", req_ready); end
    wp_hold = 1'b0;
    set_req(1, 5'd8, 32'h88);
    set_req(2, 5'd9, 32'h99);
    req_valid = 3'b111;
    settle();
    n_vec++; if (req_ready !== 3'b001) begin n_err++; $display("FAIL rsthold_restart: got %b want 001", req_ready); end
    tick();
    req_valid = 3'b000;
    settle();
    tick();
  endtask

  task automatic test_same_addr();
    do_reset();
    set_req(0, 5'd9, 32'd1);
    set_req(2, 5'd9, 32'd2);
    req_valid = 3'b101;
    settle();
    n_vec++; if (req_ready !== 3'b001) begin n_err++; $display("FAIL same_first: got %b want 001", req_ready); end
    tick();
    req_valid = 3'b100;
    settle();
    n_vec++; if (req_ready !== 3'b100) begin n_err++; $display("FAIL same_second: got %b want 100", req_ready); end
    n_vec++; if (we3 !== 1'b1 || wd3 !== 32'd1) begin n_err++; $display("FAIL same_wr1: got we3=%b wd3=%0d want 1/1", we3, wd3); end
    tick();
    req_valid = 3'b000;
    settle();
    n_vec++; if (we3 !== 1'b1 || a3 !== 5'd9 || wd3 !== 32'd2) begin n_err++; $display("FAIL same_wr2: got we3=%b a3=%0d wd3=%0d want 1/9/2", we3, a3, wd3); end
    tick();
    settle();
    n_vec++; if (we3 !== 1'b0) begin n_err++; $display("FAIL same_idle: got %b want 0", we3); end
    n_vec++; if (dut_gpr[9] !== 32'd2) begin n_err++; $display("FAIL same_gpr9: got %0d want 2", dut_gpr[9]); end
    tick();
  endtask

  task automatic test_random();
    do_reset();
    for (int c = 0; c < 400; c++) begin
      req_valid = N'($urandom_range(0, (1 << N) - 1));
      for (int i = 0; i < N; i++) begin
        set_req(i, ($urandom_range(0, 7) == 0) ? 5'd0 : AW'($urandom_range(1, 31)), $urandom);
      end
      wp_hold = ($urandom_range(0, 3) == 0);
      reset   = ($urandom_range(0, 49) == 0);
      settle();
      n_vec++; if (req_ready !== exp_ready) begin n_err++; $display("FAIL rnd_ready[%0d]: got %b want %b", c, req_ready, exp_ready); end
      n_vec++; if (we3 !== exp_we3) begin n_err++; $display("FAIL rnd_we3[%0d]: got %b want %b", c, we3, exp_we3); end
      n_vec++; if (busy !== exp_busy) begin n_err++; $display("FAIL rnd_busy[%0d]: got %b want %b", c, busy, exp_busy); end
      n_vec++; if (reg_pending !== exp_pending) begin n_err++; $display("FAIL rnd_pending[%0d]: got %h want %h", c, reg_pending, exp_pending); end
      n_vec++; if (a3 !== last_addr || wd3 !== last_data) begin n_err++; $display("FAIL rnd_a3_wd3[%0d]: got %0d/%h want %0d/%h", c, a3, wd3, last_addr, last_data); end
      tick();
    end
    reset     = 1'b0;
    wp_hold   = 1'b0;
    req_valid = '0;
    for (int c = 0; c < 2; c++) begin
      settle();
      tick();
    end
    for (int r = 0; r < 32; r++) begin
      n_vec++; if (dut_gpr[r] !== model_gpr[r]) begin n_err++; $display("FAIL rnd_gpr[%0d]: got %h want %h", r, dut_gpr[r], model_gpr[r]); end
    end
  endtask

  initial begin
    reset     = 1'b1;
    req_valid = '0;
    req_addr  = '0;
    req_data  = '0;
    wp_hold   = 1'b0;
    last_g    = N - 1;
    last_addr = '0;
    last_data = '0;
    for (int r = 0; r < 32; r++) begin
      model_gpr[r] = '0;
      dut_gpr[r]   = '0;
    end

    test_reset();
    test_single_write();
    test_round_robin();
    test_hold();
    test_zero_addr();
    test_reset_mid_hold();
    test_same_addr();
    test_random();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
